// File: rtl/dcache_ctrl.sv
//============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache
//               controller with internal tag/valid/dirty and data arrays.
//               Stalls the CPU through busywait on a miss, writes back a
//               dirty victim, fetches the new block and refills the line.
//               Optional hit/miss statistics: define DCACHE_STATS_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dcache_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           read,
    input  logic                           write,
    input  logic [ADDR_W-1:0]              address,
    input  logic [DATA_W-1:0]              writedata,
    output logic [DATA_W-1:0]              readdata,
    output logic                           busywait,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-OFFSET_W-1:0]     mem_address,
    output logic [(DATA_W<<OFFSET_W)-1:0]  mem_writedata,
    input  logic [(DATA_W<<OFFSET_W)-1:0]  mem_readdata,
    input  logic                           mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
`endif
);

    localparam int c_TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int c_BLK_W = DATA_W << OFFSET_W;
    localparam int c_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_UPDATE    = 2'd3
    } state_t;

    state_t                          r_state;
    logic                            r_mem_read;
    logic                            r_mem_write;
    logic [ADDR_W-OFFSET_W-1:0]      r_mem_address;
    logic [c_BLK_W-1:0]              r_mem_writedata;
    logic [c_BLK_W-1:0]              r_fill_block;

    logic [c_LINES-1:0]              r_valid;
    logic [c_LINES-1:0]              r_dirty;
    logic [c_TAG_W-1:0]              r_tag_array  [c_LINES];
    logic [c_BLK_W-1:0]              r_data_array [c_LINES];

    logic [c_TAG_W-1:0]              w_tag;
    logic [INDEX_W-1:0]              w_index;
    logic [OFFSET_W-1:0]             w_offset;
    logic                            w_req;
    logic                            w_idle;
    logic                            w_hit;
    logic                            w_hit_access;
    logic                            w_write_hit;
    logic                            w_victim_dirty;
    logic [c_BLK_W-1:0]              w_line_data;
    logic [DATA_W-1:0]               w_word;

    // Address split and hit detection against the indexed line
    assign w_tag          = address[ADDR_W-1 -: c_TAG_W];
    assign w_index        = address[OFFSET_W +: INDEX_W];
    assign w_offset       = address[OFFSET_W-1:0];
    assign w_req          = read | write;
    assign w_idle         = (r_state == S_IDLE);
    assign w_hit          = r_valid[w_index] && (r_tag_array[w_index] == w_tag);
    assign w_hit_access   = w_idle && w_req && w_hit;
    assign w_write_hit    = w_hit_access && write;
    assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
    assign w_line_data    = r_data_array[w_index];
    assign w_word         = w_line_data[w_offset*DATA_W +: DATA_W];

    // A simultaneous read and write is a write, so no load data is returned
    assign readdata      = (w_idle && read && !write && w_hit) ? w_word : '0;
    assign busywait      = w_idle ? (w_req && !w_hit) : 1'b1;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;

    // Miss-handling FSM; memory request outputs are registered with the state
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_fill_block    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        if (w_victim_dirty) begin
                            r_state         <= S_WRITEBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {r_tag_array[w_index], w_index};
                            r_mem_writedata <= r_data_array[w_index];
                        end else begin
                            r_state         <= S_FETCH;
                            r_mem_read      <= 1'b1;
                            r_mem_address   <= {w_tag, w_index};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_busywait) begin
                        r_state         <= S_FETCH;
                        r_mem_write     <= 1'b0;
                        r_mem_writedata <= '0;
                        r_mem_read      <= 1'b1;
                        r_mem_address   <= {w_tag, w_index};
                    end
                end
                S_FETCH: begin
                    if (!mem_busywait) begin
                        r_state       <= S_UPDATE;
                        r_mem_read    <= 1'b0;
                        r_mem_address <= '0;
                        r_fill_block  <= mem_readdata;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: refill in UPDATE, single-word store on a write hit
    always_ff @(posedge clock) begin
        if (r_state == S_UPDATE) begin
            r_data_array[w_index] <= r_fill_block;
            r_tag_array[w_index]  <= w_tag;
        end else if (w_write_hit) begin
            r_data_array[w_index][w_offset*DATA_W +: DATA_W] <= writedata;
        end
    end

    // Valid and dirty bits: the only array state cleared by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == S_UPDATE) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_pending;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating counters; r_pending marks a request that already missed so
    // its completion after the refill is not counted as a hit
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pending    <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_idle && w_req && !w_hit) begin
                r_pending <= 1'b1;
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end else if (w_hit_access) begin
                r_pending <= 1'b0;
                if (!r_pending && (r_hit_count != 16'hFFFF)) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
//============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl (default parameters).
//               Transaction-level cache model plus a fixed-latency memory.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dcache_ctrl;

    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clock = ~clock;

    dcache_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    // ---------------- memory: fixed latency, initial pattern ----------------
    logic [31:0] mem [64];
    logic [63:0] mem_wr = '0;
    int          mem_cnt = 0;

    function automatic logic [31:0] pat(input logic [5:0] b);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(int'(b) * 4 + k + 16);
        return r;
    endfunction

    function automatic logic [31:0] mem_peek(input logic [5:0] b);
        return mem_wr[b] ? mem[b] : pat(b);
    endfunction

    assign mem_readdata = mem_peek(mem_address);
    assign mem_busywait = (mem_read || mem_write) ? (mem_cnt != LAT - 1) : 1'b1;

    always @(posedge clock) begin
        if (mem_read || mem_write) begin
            if (mem_cnt == LAT - 1) begin
                mem_cnt <= 0;
                if (mem_write) begin
                    mem[mem_address]    <= mem_writedata;
                    mem_wr[mem_address] <= 1'b1;
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // ---------------- cache model ----------------
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    logic        check_en = 1'b0;
    logic        exp_bw, exp_mr, exp_mw, chk_rd;
    logic [5:0]  exp_ma;
    logic [31:0] exp_mwd;
    logic [7:0]  exp_rd;

    // observations used for the hand-computed literal checks
    int          cap_bw, cap_mr;
    logic        saw_mw;
    logic [5:0]  cap_wb_addr, cap_fa;
    logic [31:0] cap_wb_data;
    logic [7:0]  cap_rd;

    // Per-cycle comparison of every DUT output against the model expectation
    always @(negedge clock) begin
        if (check_en) begin
            chk("busywait",      32'(busywait),      32'(exp_bw));
            chk("mem_read",      32'(mem_read),      32'(exp_mr));
            chk("mem_write",     32'(mem_write),     32'(exp_mw));
            chk("mem_address",   32'(mem_address),   32'(exp_ma));
            chk("mem_writedata", mem_writedata,      exp_mwd);
            if (chk_rd) chk("readdata", 32'(readdata), 32'(exp_rd));
            if (busywait) cap_bw++;
            if (mem_read) begin cap_mr++; cap_fa = mem_address; end
            if (mem_write) begin
                saw_mw = 1'b1; cap_wb_addr = mem_address; cap_wb_data = mem_writedata;
            end
            if (read && !busywait) cap_rd = readdata;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_caps();
        cap_bw = 0; cap_mr = 0; saw_mw = 1'b0;
        cap_wb_addr = '0; cap_fa = '0; cap_wb_data = '0; cap_rd = '0;
    endtask

    task automatic idle_exp();
        exp_bw = 1'b0; exp_mr = 1'b0; exp_mw = 1'b0;
        exp_ma = '0; exp_mwd = '0; chk_rd = 1'b1; exp_rd = '0;
    endtask

    // One CPU request, expectations derived from the model cycle by cycle
    task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  t, i;
        logic [1:0]  o;
        logic [31:0] fill;
        t = a[7:5]; i = a[4:2]; o = a[1:0];
        clear_caps();
        read = rd; write = wr; address = a; writedata = wd;
        idle_exp();
        if (!(m_valid[i] && m_tag[i] == t)) begin
            exp_bw = 1'b1; chk_rd = 1'b0;
            cyc();
            if (m_valid[i] && m_dirty[i]) begin
                exp_mw = 1'b1; exp_ma = {m_tag[i], i}; exp_mwd = m_data[i];
                repeat (LAT) cyc();
                exp_mw = 1'b0; exp_mwd = '0;
            end
            exp_mr = 1'b1; exp_ma = {t, i};
            fill = mem_peek({t, i});
            repeat (LAT) cyc();
            exp_mr = 1'b0; exp_ma = '0;
            cyc();
            m_valid[i] = 1'b1; m_tag[i] = t; m_data[i] = fill; m_dirty[i] = 1'b0;
        end
        exp_bw = 1'b0; chk_rd = 1'b1;
        exp_rd = (rd && !wr) ? m_data[i][o*8 +: 8] : 8'h00;
        cyc();
        if (wr) begin
            m_data[i][o*8 +: 8] = wd;
            m_dirty[i] = 1'b1;
        end
        read = 1'b0; write = 1'b0;
        idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        idle_exp();
        clear_caps();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0; m_dirty[k] = 1'b0; m_tag[k] = '0; m_data[k] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busywait",      32'(busywait),    32'd0);
        chk("rst_mem_read",      32'(mem_read),    32'd0);
        chk("rst_mem_write",     32'(mem_write),   32'd0);
        chk("rst_mem_address",   32'(mem_address), 32'd0);
        chk("rst_mem_writedata", mem_writedata,    32'd0);
        chk("rst_readdata",      32'(readdata),    32'd0);
        reset = 1'b1;
        check_en = 1'b1;
        cyc();

        // clean miss on an empty cache
        do_req(1'b1, 1'b0, 8'h25, 8'h00);
        chk("s1_readdata",   32'(cap_rd), 32'h35);
        chk("s1_stall",      cap_bw,      32'd7);
        chk("s1_mr_cycles",  cap_mr,      32'd5);
        chk("s1_fetch_addr", 32'(cap_fa), 32'h09);

        // write hit, then read back with no stall
        do_req(1'b0, 1'b1, 8'h25, 8'hAB);
        chk("s2_write_stall", cap_bw, 32'd0);
        do_req(1'b1, 1'b0, 8'h25, 8'h00);
        chk("s2_readdata", 32'(cap_rd), 32'hAB);
        chk("s2_stall",    cap_bw,      32'd0);

        // dirty conflict miss: writeback then fetch
        do_req(1'b1, 1'b0, 8'hA5, 8'h00);
        chk("s3_saw_wb",     32'(saw_mw),             32'd1);
        chk("s3_wb_addr",    32'(cap_wb_addr),        32'h09);
        chk("s3_wb_byte1",   32'(cap_wb_data[15:8]),  32'hAB);
        chk("s3_fetch_addr", 32'(cap_fa),             32'h29);
        chk("s3_stall",      cap_bw,                  32'd12);
`ifdef DCACHE_STATS_EN
        chk("hit_count",  32'(hit_count),  32'd2);
        chk("miss_count", 32'(miss_count), 32'd2);
`endif

        // clean conflict miss: fetch only
        do_req(1'b1, 1'b0, 8'h04, 8'h00);
        chk("s4_no_wb",      32'(saw_mw), 32'd0);
        chk("s4_fetch_addr", 32'(cap_fa), 32'h01);
        chk("s4_readdata",   32'(cap_rd), 32'h14);

        // write miss (allocate) on another line and other offsets
        do_req(1'b0, 1'b1, 8'h33, 8'h5A);
        do_req(1'b1, 1'b0, 8'h33, 8'h00);
        chk("s5_readdata", 32'(cap_rd), 32'h5A);
        do_req(1'b1, 1'b0, 8'h32, 8'h00);
        do_req(1'b1, 1'b0, 8'h06, 8'h00);

        // reset in the middle of a fetch
        check_en = 1'b0;
        read = 1'b1; address = 8'h25;
        repeat (3) cyc();
        chk("s6_fetching", 32'(mem_read), 32'd1);
        reset = 1'b0; read = 1'b0;
        cyc();
        chk("s6_mem_read_drop", 32'(mem_read), 32'd0);
        chk("s6_busywait_drop", 32'(busywait), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0; m_dirty[k] = 1'b0;
        end
        cyc();
        idle_exp();
        check_en = 1'b1;
        do_req(1'b1, 1'b0, 8'h25, 8'h00);
        chk("s6_remiss_stall", cap_bw,      32'd7);
        chk("s6_readdata",     32'(cap_rd), 32'hAB);
        cyc();
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised direct-mapped, write-back, write-allocate data cache with tag/valid/dirty and data arrays held internally. Sits between the CPU load/store path and the block-wide data memory, stalling the CPU through `busywait` on a miss. Successor to the fixed 8-bit/8-line cache FSM: line count, block size and word width are generic, the tag compare and arrays live inside the block, and a dedicated line-update state is added.

## Interface
Parameters:
- `ADDR_W`, 8, CPU byte-address width
- `DATA_W`, 8, CPU word width
- `INDEX_W`, 3, index bits; lines = 2^INDEX_W
- `OFFSET_W`, 2, word-offset bits; words per block = 2^OFFSET_W; `BLK_W` = DATA_W<<OFFSET_W
- Tag width `TAG_W` = ADDR_W-INDEX_W-OFFSET_W (must be ≥1)

Ports (one clock; reset is synchronous and active-low):
- `clock` in 1 — all state updates on rising edge
- `reset` in 1 — synchronous, active-low
- `read` in 1 — CPU load request, held until `busywait` low
- `write` in 1 — CPU store request, held until `busywait` low
- `address` in ADDR_W — {tag, index, offset}
- `writedata` in DATA_W — store data
- `readdata` out DATA_W — load data
- `busywait` out 1 — CPU stall
- `mem_read` out 1 — block fetch request
- `mem_write` out 1 — block write-back request
- `mem_address` out ADDR_W-OFFSET_W — block address {tag, index}
- `mem_writedata` out BLK_W — victim block
- `mem_readdata` in BLK_W — fetched block
- `mem_busywait` in 1 — memory busy; transfer complete on the first cycle it is low
- `hit_count`, `miss_count` out 16 — only with `DCACHE_STATS_EN`

## Operation
- Hit = valid[index] && tag_array[index]==tag. `read`&&`write` together is treated as a write.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE: on hit, no stall. Read: `readdata` = selected word, combinational. Write: word written and dirty set at the next edge. On miss: to WRITEBACK if victim valid&&dirty, else to FETCH.
- WRITEBACK: `mem_write`=1, `mem_address`={stored tag, index}, `mem_writedata`=stored block. When `mem_busywait` is low, go to FETCH.
- FETCH: `mem_read`=1, `mem_address`={tag, index}. When `mem_busywait` is low, capture `mem_readdata` and go to UPDATE.
- UPDATE: write block, tag, valid=1, dirty=0. Return to IDLE. The held request then hits and completes there; for writes, dirty is set at that point.
- `busywait` = (read||write)&&!hit in IDLE; 1 in WRITEBACK/FETCH/UPDATE.
- Outputs when inactive: `mem_read`=`mem_write`=0, `mem_address`=0, `mem_writedata`=0, `readdata`=0 when `read` is low.

## Timing
- Reset (`reset` low at an edge): state=IDLE, all valid/dirty=0, counters=0.
  - Reset values: `busywait`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `readdata`=0.
  - A reset mid-WRITEBACK/FETCH abandons the transfer; memory requests drop in the next cycle.
- Read hit: 0 stall cycles. Write hit: 0 stall cycles, array update at the edge.
- Clean miss: FETCH (≥1 cycle, memory latency) + UPDATE (1) + IDLE completion. Stall = memory latency + 2 cycles.
- Dirty miss: adds the WRITEBACK latency.
- `mem_read`/`mem_write` are held stable until `mem_busywait` is sampled low. They are never both high.
- Data/tag arrays are not reset; only valid and dirty are cleared.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments once per request completed as a first-cycle hit.
  - `miss_count` increments once per IDLE→WRITEBACK/FETCH transition.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters. Address 0x25 = tag 001, index 001, offset 01. Memory latency is 5 cycles.
- Reset, then read 0x25 → `busywait` high same cycle, `mem_read`=1 with `mem_address`=0x09 for 5 cycles, UPDATE 1 cycle. `readdata` = byte 1 of the fetched block, then `busywait` low.
- Write 0xAB to 0x25 after the fill → no stall. Subsequent read of 0x25 returns 0xAB in the same cycle.
- Read 0xA5 (tag 101, index 001) with line 1 dirty:
  - WRITEBACK with `mem_address`=0x09 and `mem_writedata` holding 0xAB in bits 15:8.
  - Then FETCH with `mem_address`=0x29.
- Read 0x04 (line 1 valid, clean, tag mismatch; line 0 invalid) → FETCH only, with no `mem_write` pulse.
- Pull `reset` low during FETCH → next cycle `mem_read`=0 and `busywait`=0. Re-read 0x25 misses again.
- With `DCACHE_STATS_EN`: the first three scenarios give `hit_count`=2, `miss_count`=2.
